// File: rtl/hc595_chain_driver_if.sv
// Parallel-side bus of the 74HC595 chain driver: the frame request
// from the upstream encoder plus the status and serial pins it drives.
interface hc595_chain_driver_if #(
   parameter int NUM_ICS = 2
);
   localparam int N = 8 * NUM_ICS;

   logic         trigger_i;
   logic [N-1:0] data_i;
   logic         busy_o;
   logic         done_o;
   logic         sclk_o;
   logic         data_o;
   logic         latch_en_o;

   // Requester side: issues frames, observes status and pins.
   modport master (
      output trigger_i,
      output data_i,
      input  busy_o,
      input  done_o,
      input  sclk_o,
      input  data_o,
      input  latch_en_o
   );

   // Driver side: accepts frames, drives status and pins.
   modport slave (
      input  trigger_i,
      input  data_i,
      output busy_o,
      output done_o,
      output sclk_o,
      output data_o,
      output latch_en_o
   );
endinterface

// File: rtl/hc595_chain_driver.sv
// Serializer for a daisy-chain of 74HC595s. A one-cycle trigger captures
// an N-bit frame, which is clocked out on SCLK/DATA with DIV system clocks
// per SCLK phase, followed by a DIV-cycle RCLK pulse so the whole frame
// appears on the display at once. busy/done let the refresh multiplexer
// pace frames; a held trigger yields back-to-back frames.
module hc595_chain_driver #(
   parameter int NUM_ICS   = 2,
   parameter int DIV       = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   hc595_chain_driver_if.slave bus
);
   localparam int N     = 8 * NUM_ICS;
   localparam int CNT_W = $clog2(N);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

   state_t           state_r;
   logic [N-1:0]     shreg_r;
   logic [CNT_W-1:0] bit_cnt_r;
   logic [7:0]       div_cnt_r;
   logic             busy_r;
   logic             done_r;
   logic             sclk_r;
   logic             data_r;
   logic             latch_r;

   logic             div_last_s;
   logic             first_bit_s;
   logic             next_bit_s;
   logic [N-1:0]     shifted_s;

   // Divider terminal count: each phase lasts exactly DIV cycles.
   assign div_last_s  = (div_cnt_r == 8'(DIV - 1));

   // Bit selection depends on shift direction; the shift register always
   // keeps the bit currently on data_o at its outgoing end.
   assign first_bit_s = (MSB_FIRST != 0) ? bus.data_i[N-1] : bus.data_i[0];
   assign next_bit_s  = (MSB_FIRST != 0) ? shreg_r[N-2]    : shreg_r[1];
   assign shifted_s   = (MSB_FIRST != 0) ? {shreg_r[N-2:0], 1'b0}
                                         : {1'b0, shreg_r[N-1:1]};

   // Sequencer: state, datapath and every output register in one process.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r   <= IDLE;
         shreg_r   <= '0;
         bit_cnt_r <= '0;
         div_cnt_r <= 8'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         sclk_r    <= 1'b0;
         data_r    <= 1'b0;
         latch_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               sclk_r  <= 1'b0;
               latch_r <= 1'b0;
               if (bus.trigger_i) begin
                  shreg_r   <= bus.data_i;
                  bit_cnt_r <= CNT_W'(N - 1);
                  div_cnt_r <= 8'd0;
                  busy_r    <= 1'b1;
                  data_r    <= first_bit_s;
                  state_r   <= SHIFT_LO;
               end else begin
                  busy_r <= 1'b0;
                  data_r <= 1'b0;
               end
            end
            SHIFT_LO: begin
               if (div_last_s) begin
                  div_cnt_r <= 8'd0;
                  sclk_r    <= 1'b1;
                  state_r   <= SHIFT_HI;
               end else begin
                  div_cnt_r <= div_cnt_r + 8'd1;
               end
            end
            SHIFT_HI: begin
               if (div_last_s) begin
                  div_cnt_r <= 8'd0;
                  sclk_r    <= 1'b0;
                  if (bit_cnt_r != CNT_W'(0)) begin
                     bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                     shreg_r   <= shifted_s;
                     data_r    <= next_bit_s;
                     state_r   <= SHIFT_LO;
                  end else begin
                     data_r  <= 1'b0;
                     latch_r <= 1'b1;
                     state_r <= LATCH;
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + 8'd1;
               end
            end
            LATCH: begin
               if (div_last_s) begin
                  div_cnt_r <= 8'd0;
                  latch_r   <= 1'b0;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  div_cnt_r <= div_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r   <= IDLE;
               div_cnt_r <= 8'd0;
               busy_r    <= 1'b0;
               sclk_r    <= 1'b0;
               data_r    <= 1'b0;
               latch_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o     = busy_r;
   assign bus.done_o     = done_r;
   assign bus.sclk_o     = sclk_r;
   assign bus.data_o     = data_r;
   assign bus.latch_en_o = latch_r;
endmodule

// File: doc/hc595_chain_driver.md
# hc595_chain_driver

Serializer that drives a daisy-chain of 74HC595 shift registers from a parallel word. It sits directly downstream of the display-frame encoder in the 7-segment clock: it accepts a 16-bit (default) segment/digit frame on a one-cycle trigger. It clocks the frame out on SCLK/DATA, then pulses the storage-register latch so the new frame appears on the display in one step. It also exposes busy/done status so the upstream multiplexer can pace digit refresh.

## Interface

Parameters:
- NUM_ICS, 2, number of chained 74HC595s; frame width N = 8*NUM_ICS
- DIV, 1, system clocks per SCLK phase (low or high) and per latch pulse; legal range 1..255
- MSB_FIRST, 1, 1: data_i[N-1] shifted first; 0: data_i[0] shifted first

Ports:
- clk_i  in  1  system clock (8.192 kHz in the clock design)
- rst_i  in  1  one clock; reset is synchronous and active-low
- trigger_i  in  1  start request, sampled only in IDLE
- data_i  in  N  frame to shift; captured on the accepting edge only
- busy_o  out  1  high from accept until the frame is latched
- done_o  out  1  one-cycle pulse after the latch pulse ends
- sclk_o  out  1  595 SRCLK
- data_o  out  1  595 SER
- latch_en_o  out  1  595 RCLK

## Operation

- All outputs are registered. On reset (rst_i low at a posedge), the block clears the state, shift register, bit counter and divider counter to 0. It also drives every output to 0.
- FSM states:
  - IDLE: waits for trigger_i.
  - SHIFT_LO: sclk_o=0 and data_o = the current bit.
  - SHIFT_HI: sclk_o=1 and data_o is held.
  - LATCH: latch_en_o=1, sclk_o=0, data_o=0.
- IDLE → SHIFT_LO: on trigger_i=1, the block captures data_i and sets the bit counter to N-1 and the divider to 0. On the same edge it sets busy_o=1 and drives the first bit on data_o.
- SHIFT_LO → SHIFT_HI: after DIV cycles in SHIFT_LO.
- SHIFT_HI, after DIV cycles:
  - if the bit counter ≠ 0: decrement the counter, shift to the next bit, go to SHIFT_LO;
  - otherwise go to LATCH.
- LATCH → IDLE: after DIV cycles. On this edge latch_en_o=0, busy_o=0 and done_o=1; done_o falls on the following edge.
- Bit order:
  - MSB_FIRST=1: the block shifts out data_i[N-1] first and data_i[0] last. Bit data_i[0] ends at QA of the first IC; data_i[N-1] ends at QH of the last IC.
  - MSB_FIRST=0: the order is reversed.
- trigger_i while busy_o=1 is ignored (not queued). data_i changes during a frame have no effect.
- trigger_i=1 during the done_o cycle (IDLE) is accepted, so a held trigger gives back-to-back frames.
- data_o is 0 in IDLE and LATCH.
- sclk_o and latch_en_o are never high in the same cycle.
- Reset mid-frame: the next edge forces IDLE and all outputs 0. No latch pulse is issued, so the 595 outputs keep the previously latched frame.

## Timing

- The accept edge is edge 0. Bit k (k = 0..N-1) behaves as follows:
  - data_o is valid from edge 2·DIV·k.
  - sclk_o rises at edge 2·DIV·k + DIV.
  - sclk_o falls at edge 2·DIV·(k+1).
- Data setup before the SCLK rise is DIV cycles. Data hold after the rise is DIV cycles.
- latch_en_o is high from edge 2·DIV·N to edge 2·DIV·N + DIV.
- done_o is high for the single cycle starting at edge T = 2·DIV·N + DIV.
- busy_o is high for exactly T cycles.
- With trigger_i held high, the frame period is T+1 cycles. For defaults, T = 33 and the period is 34 cycles.
- Bit counter: width ceil(log2(N)). Divider counter: 8 bits, with terminal count DIV-1.

## Test plan

- Reset: hold rst_i=0 for 3 cycles with trigger_i=1 → sclk_o, data_o, latch_en_o, busy_o and done_o all 0. Release reset → accept happens on the first edge with rst_i=1.
- Single frame, defaults, data_i=16'hA5C3, one-cycle trigger → data_o sampled at the 16 sclk_o rises is 1010 0101 1100 0011. Exactly 16 rises occur. latch_en_o is high in cycle 32 only. done_o is high in cycle 33 only. busy_o is high in cycles 0..32.
- DIV=3, NUM_ICS=1, data_i=8'h81 → each sclk_o phase lasts 3 cycles. The bit sequence is 1000 0001. latch_en_o is high for 3 cycles starting at cycle 48. done_o fires at cycle 51.
- Trigger during busy:
  - pulse trigger_i at cycles 0 and 10 with data 16'hFFFF then 16'h0000 → only one frame, all ones, and exactly one done_o;
  - holding trigger_i with data 16'h1234 → done_o every 34 cycles and identical bit streams.
- Reset mid-frame: assert rst_i=0 at cycle 9 → all outputs 0 from the next edge. No latch_en_o pulse and no done_o. A new trigger afterwards produces a full, correct frame.
- MSB_FIRST=0, data_i=16'h0001 → the first bit shifted is 1 and the remaining 15 bits are 0.
